// File: rtl/pilot_pkg.sv
// Autopilot mode controller: shared types and constants.
//   mode_e      - operating mode as seen on the 'mode' output
//   DEG_FULL    - one full compass turn in degrees
//   DEF_*       - default values for the controller parameters
package pilot_pkg;

  typedef enum logic [1:0] {
    MODE_STBY  = 2'd0,
    MODE_AUTO  = 2'd1,
    MODE_FAULT = 2'd2
  } mode_e;

  localparam int DEG_FULL = 360;

  localparam int DEF_DEADBAND     = 2;
  localparam int DEF_GAIN         = 8;
  localparam int DEF_END_MIN      = 16;
  localparam int DEF_END_MAX      = 240;
  localparam int DEF_JOG_CYCLES   = 25_000_000;
  localparam int DEF_BIP_CYCLES   = 5_000_000;
  localparam int DEF_HEAD_TIMEOUT = 50_000_000;

  localparam logic [7:0] DUTY_MAX  = 8'hFF;
  localparam logic [7:0] ADC_RESET = 8'd128;

endpackage

// File: rtl/pilot_mode_ctrl_if.sv
// Pilot controller bus: buttons, compass and verin feedback in; verin
// drive, LEDs, buzzer and mode out.
//   master - stimulus side (drives buttons/sensors, reads drive/indicators)
//   slave  - controller side
interface pilot_mode_ctrl_if;
  logic       bp_babord_p;
  logic       bp_tribord_p;
  logic       bp_stby_p;
  logic       cap_valid;
  logic [8:0] cap_heading;
  logic       adc_valid;
  logic [7:0] adc_angle;
  logic       verin_en;
  logic       verin_sens;
  logic [7:0] verin_duty;
  logic       led_stby;
  logic       led_babord;
  logic       led_tribord;
  logic       bip_out;
  logic [1:0] mode;

  modport master (
    output bp_babord_p, bp_tribord_p, bp_stby_p,
    output cap_valid, cap_heading, adc_valid, adc_angle,
    input  verin_en, verin_sens, verin_duty,
    input  led_stby, led_babord, led_tribord, bip_out, mode
  );

  modport slave (
    input  bp_babord_p, bp_tribord_p, bp_stby_p,
    input  cap_valid, cap_heading, adc_valid, adc_angle,
    output verin_en, verin_sens, verin_duty,
    output led_stby, led_babord, led_tribord, bip_out, mode
  );
endinterface

// File: rtl/heading_err.sv
// Signed heading error setpoint - heading, wrapped into -180..+179, plus
// its magnitude. Purely combinational.
//   setpoint, heading - 0..359 degrees
//   err               - wrapped signed error
//   err_abs           - |err|, 0..180
module heading_err
  import pilot_pkg::*;
(
  input  logic [8:0]        setpoint,
  input  logic [8:0]        heading,
  output logic signed [9:0] err,
  output logic [9:0]        err_abs
);
  localparam logic signed [10:0] FULL = 11'(DEG_FULL);
  localparam logic signed [10:0] HALF = 11'(DEG_FULL / 2);

  logic signed [10:0] raw;
  logic signed [10:0] diff;

  assign raw = $signed({2'b00, setpoint}) - $signed({2'b00, heading});

  always_comb begin
    diff = raw;
    if (raw >= HALF)      diff = raw - FULL;
    else if (raw < -HALF) diff = raw + FULL;
  end

  assign err     = $signed(diff[9:0]);
  assign err_abs = diff[10] ? 10'(-diff) : diff[9:0];
endmodule

// File: rtl/pilot_mode_ctrl.sv
// Autopilot mode controller: STBY (manual jog), AUTO (heading hold) and
// FAULT (compass lost). All outputs are registered.
//   clk, reset_n - clock, async active-low reset
//   bus (slave)  - buttons, compass, verin position in; verin drive,
//                  LEDs, buzzer, mode out
module pilot_mode_ctrl
  import pilot_pkg::*;
#(
  parameter int DEADBAND     = DEF_DEADBAND,
  parameter int GAIN         = DEF_GAIN,
  parameter int END_MIN      = DEF_END_MIN,
  parameter int END_MAX      = DEF_END_MAX,
  parameter int JOG_CYCLES   = DEF_JOG_CYCLES,
  parameter int BIP_CYCLES   = DEF_BIP_CYCLES,
  parameter int HEAD_TIMEOUT = DEF_HEAD_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  pilot_mode_ctrl_if.slave bus
);
  localparam logic [9:0]  DB_C    = 10'(DEADBAND);
  localparam logic [7:0]  EMIN_C  = 8'(END_MIN);
  localparam logic [7:0]  EMAX_C  = 8'(END_MAX);
  localparam logic [31:0] JOG_C   = 32'(JOG_CYCLES);
  localparam logic [31:0] BIP_C   = 32'(BIP_CYCLES);
  localparam logic [31:0] WD_C    = 32'(HEAD_TIMEOUT);
  localparam logic [8:0]  SP_LAST = 9'(DEG_FULL - 1);

  mode_e       mode_q, mode_n;
  logic [8:0]  sp_q, sp_n, hd_q;
  logic        seen_q, cap_d_q;
  logic [7:0]  adc_q, adc_n;
  logic [31:0] jog_q, jog_n, bip_q, bip_n, wd_q, wd_n;
  logic        jdir_q, jdir_n;
  logic        en_q, en_n, sens_q, sens_n;
  logic [7:0]  duty_q, duty_n;
  logic        led_s_q, led_b_q, led_t_q, bip_out_q;

  logic signed [9:0] err;
  logic [9:0]        err_abs;
  logic [31:0]       prod;
  logic              side_p, auto_en, auto_sens, fault_n;
  logic [7:0]        auto_duty;

  heading_err u_err (
    .setpoint (sp_q),
    .heading  (hd_q),
    .err      (err),
    .err_abs  (err_abs)
  );

  // stby wins over a side button; both side buttons together cancel out
  assign side_p    = (bus.bp_babord_p ^ bus.bp_tribord_p) & ~bus.bp_stby_p;
  assign prod      = 32'(err_abs) * 32'(GAIN);
  assign auto_en   = err_abs > DB_C;
  assign auto_sens = err > 10'sd0;
  assign auto_duty = !auto_en ? 8'd0 : (prod > 32'(DUTY_MAX)) ? DUTY_MAX : prod[7:0];
  assign adc_n     = bus.adc_valid ? bus.adc_angle : adc_q;
  assign fault_n   = (mode_n == MODE_FAULT);

  always_comb begin
    mode_n = mode_q;
    sp_n   = sp_q;
    jog_n  = (jog_q != '0) ? jog_q - 32'd1 : '0;
    jdir_n = jdir_q;
    bip_n  = (bip_q != '0) ? bip_q - 32'd1 : '0;
    wd_n   = '0;
    en_n   = en_q;
    sens_n = sens_q;
    duty_n = duty_q;
    // every stby press beeps, including a refused AUTO request
    if (bus.bp_stby_p) bip_n = BIP_C;
    case (mode_q)
      MODE_STBY: begin
        if (bus.bp_stby_p) begin
          if (seen_q) begin
            mode_n = MODE_AUTO;
            sp_n   = hd_q;
            jog_n  = '0;
          end
        end else if (side_p) begin
          jog_n  = JOG_C;
          jdir_n = bus.bp_tribord_p;
          bip_n  = BIP_C;
        end
        if (jog_n != '0) begin
          en_n   = 1'b1;
          sens_n = jdir_n;
          duty_n = DUTY_MAX;
        end else begin
          en_n   = 1'b0;
          duty_n = '0;
        end
      end
      MODE_AUTO: begin
        jog_n = '0;
        wd_n  = bus.cap_valid ? '0 : wd_q + 32'd1;
        if (bus.bp_stby_p) begin
          mode_n = MODE_STBY;
          en_n   = 1'b0;
          duty_n = '0;
        end else if (wd_n == WD_C) begin
          mode_n = MODE_FAULT;
          en_n   = 1'b0;
          duty_n = '0;
        end else begin
          // heading was latched on the previous edge: recompute drive now,
          // hold it otherwise
          if (cap_d_q) begin
            en_n   = auto_en;
            sens_n = auto_sens;
            duty_n = auto_duty;
          end
          if (side_p) begin
            if (bus.bp_tribord_p) sp_n = (sp_q == SP_LAST) ? 9'd0 : sp_q + 9'd1;
            else                  sp_n = (sp_q == 9'd0) ? SP_LAST : sp_q - 9'd1;
            bip_n = BIP_C;
          end
        end
      end
      default: begin
        jog_n  = '0;
        en_n   = 1'b0;
        duty_n = '0;
        if (bus.bp_stby_p) mode_n = MODE_STBY;
      end
    endcase
    // end-stop cut, any mode; the held AUTO drive stays off until next heading
    if ((sens_n && adc_n >= EMAX_C) || (!sens_n && adc_n <= EMIN_C)) begin
      en_n   = 1'b0;
      duty_n = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MODE_STBY;
      sp_q      <= '0;
      hd_q      <= '0;
      seen_q    <= 1'b0;
      cap_d_q   <= 1'b0;
      adc_q     <= ADC_RESET;
      jog_q     <= '0;
      jdir_q    <= 1'b0;
      bip_q     <= '0;
      wd_q      <= '0;
      en_q      <= 1'b0;
      sens_q    <= 1'b0;
      duty_q    <= '0;
      led_s_q   <= 1'b1;
      led_b_q   <= 1'b0;
      led_t_q   <= 1'b0;
      bip_out_q <= 1'b0;
    end else begin
      mode_q    <= mode_n;
      sp_q      <= sp_n;
      hd_q      <= bus.cap_valid ? bus.cap_heading : hd_q;
      seen_q    <= seen_q | bus.cap_valid;
      cap_d_q   <= bus.cap_valid;
      adc_q     <= adc_n;
      jog_q     <= jog_n;
      jdir_q    <= jdir_n;
      bip_q     <= bip_n;
      wd_q      <= wd_n;
      en_q      <= en_n;
      sens_q    <= sens_n;
      duty_q    <= duty_n;
      led_s_q   <= fault_n | (mode_n == MODE_STBY);
      led_b_q   <= fault_n | (en_n & ~sens_n);
      led_t_q   <= fault_n | (en_n & sens_n);
      bip_out_q <= fault_n | (bip_n != '0);
    end
  end

  assign bus.mode        = mode_q;
  assign bus.verin_en    = en_q;
  assign bus.verin_sens  = sens_q;
  assign bus.verin_duty  = duty_q;
  assign bus.led_stby    = led_s_q;
  assign bus.led_babord  = led_b_q;
  assign bus.led_tribord = led_t_q;
  assign bus.bip_out     = bip_out_q;
endmodule
